l1_out_accum: RTL and testbench

Result-side consumer for the 4b multiplier cell running in input-shared (IN_IN), bitgroup-in-MAC mode. It accepts one packed 16-bit product word per beat, splits it into 1, 2 or 4 unsigned lanes according to the precision code, and accumulates each lane over a fixed window of ACC_LEN beats. At the end of each window it emits the lane sums on a valid/ready output. It sits between the L1 multiplier array and the L2 adder tree / output buffer.

---
 rtl/l1_out_accum_pkg.sv | 44 ++++
 rtl/l1_out_accum_lane_split.sv | 16 +
 rtl/l1_out_accum.sv | 116 +++++++++++
 tb/tb_l1_out_accum.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/l1_out_accum_pkg.sv
// Shared helpers for the L1 result path of the 4b multiplier cell.
//   - precision codes (PREC_4X4 / PREC_4X2 / PREC_2X2; code 2'b10 is illegal)
//   - lanes_t: four 16-bit lanes, lane 0 in the MSB position
//   - norm_prec: maps the illegal code onto 2x2
//   - lane_split: unpacks one 16-bit product word into zero-extended lanes
package l1_out_accum_pkg;

    localparam logic [1:0] PREC_4X4 = 2'b00;
    localparam logic [1:0] PREC_4X2 = 2'b01;
    localparam logic [1:0] PREC_2X2 = 2'b11;

    // Ascending index so that lane 0 sits at the MSB end of the flat vector.
    typedef logic [0:3][15:0] lanes_t;

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } acc_state_t;

    function automatic logic [1:0] norm_prec(input logic [1:0] prec);
        return (prec == 2'b10) ? PREC_2X2 : prec;
    endfunction

    function automatic lanes_t lane_split(input logic [1:0] prec, input logic [15:0] word);
        lanes_t l;
        l = '0;
        case (prec)
            PREC_4X4: l[0] = word;
            PREC_4X2: begin
                l[0] = {8'h00, word[15:8]};
                l[1] = {8'h00, word[7:0]};
            end
            default: begin
                // 2x2, and the illegal code which behaves as 2x2
                l[0] = {12'h000, word[15:12]};
                l[1] = {12'h000, word[11:8]};
                l[2] = {12'h000, word[7:4]};
                l[3] = {12'h000, word[3:0]};
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/l1_out_accum_lane_split.sv
// l1_lane_split: combinational wrapper around lane_split so the L2 side can
// reuse the same unpacking.
//   prec  in  2   precision code
//   word  in  16  packed product word
//   lanes out 64  four zero-extended 16-bit lanes, lane 0 in [63:48]
module l1_lane_split
    import l1_out_accum_pkg::*;
(
    input  logic [1:0]  prec,
    input  logic [15:0] word,
    output logic [63:0] lanes
);

    assign lanes = lane_split(prec, word);

endmodule

// File: rtl/l1_out_accum.sv
// l1_out_accum: accumulates packed product words per lane over a window of
// ACC_LEN beats and presents the lane sums on a valid/ready output register.
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   prec      in   precision code (00 4x4, 01 4x2, 11 2x2; 10 illegal)
//   flush     in   abort the window in progress
//   in_valid  in   product word valid
//   in_ready  out  product word can be accepted
//   in_data   in   16-bit packed product word
//   out_valid out  window result valid
//   out_ready in   downstream accepts the result
//   out_data  out  4 x ACC_WIDTH lane sums, lane 0 in the MSB field
//   out_prec  out  precision the result was accumulated with
module l1_out_accum
    import l1_out_accum_pkg::*;
#(
    parameter int ACC_LEN   = 16,
    parameter int ACC_WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             prec,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0]            in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*ACC_WIDTH-1:0] out_data,
    output logic [1:0]             out_prec
);

    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

    if (ACC_LEN < 1 || ACC_WIDTH < 16 + $clog2(ACC_LEN)) begin : g_bad_params
        $error("l1_out_accum: ACC_LEN must be >= 1 and ACC_WIDTH >= 16 + clog2(ACC_LEN)");
    end

    acc_state_t                  state;
    logic [1:0]                  win_prec;
    logic [CNT_W-1:0]            count;
    logic [0:3][ACC_WIDTH-1:0]   acc;
    logic [0:3][ACC_WIDTH-1:0]   sum;
    logic [1:0]                  eff_prec;
    logic [63:0]                 lanes_flat;
    lanes_t                      lanes;
    logic                        is_last;
    logic                        accept;

    // The first beat of a window splits with the live code (and latches it);
    // later beats use the latched window precision.
    assign eff_prec = (state == ST_IDLE) ? norm_prec(prec) : win_prec;

    l1_lane_split u_split (
        .prec  (eff_prec),
        .word  (in_data),
        .lanes (lanes_flat)
    );

    assign lanes = lanes_flat;

    // acc is zero whenever the FSM is idle, so acc + lane also covers the
    // first-beat load.
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sum[i] = acc[i] + ACC_WIDTH'(lanes[i]);
        end
    end

    // count is 0 in IDLE, so this also marks the single beat when ACC_LEN = 1.
    assign is_last  = (count == CNT_W'(ACC_LEN - 1));
    assign in_ready = rst_n && !flush && !(is_last && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            win_prec  <= PREC_4X4;
            count     <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_prec  <= PREC_4X4;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (flush) begin
                state <= ST_IDLE;
                count <= '0;
                acc   <= '0;
            end else if (accept) begin
                if (is_last) begin
                    // A new result takes priority over the drain above, which
                    // gives same-cycle drain and refill.
                    out_valid <= 1'b1;
                    out_data  <= sum;
                    out_prec  <= eff_prec;
                    acc       <= '0;
                    count     <= '0;
                    state     <= ST_IDLE;
                end else begin
                    acc      <= sum;
                    count    <= count + 1'b1;
                    win_prec <= eff_prec;
                    state    <= ST_ACCUM;
                end
            end
        end
    end

    prec_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && in_ready) |-> (prec != 2'b10));

endmodule

// File: tb/tb_l1_out_accum.sv
module tb_l1_out_accum;

    localparam int L = 4;
    localparam int W = 20;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     prec = 2'b00;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [15:0]    in_data = 16'h0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [4*W-1:0] out_data;
    logic [1:0]     out_prec;

    int checks = 0;
    int failures = 0;

    // Reference model: per-window lane sums and pending results.
    int          m_cnt = 0;
    int          m_sum[4];
    logic [1:0]  m_prec = 2'b00;
    logic [81:0] exp_q[$];

    always #5 clk = ~clk;

    l1_out_accum #(.ACC_LEN(L), .ACC_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prec      (prec),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_prec  (out_prec)
    );

    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [79:0] pk(input int a, input int b, input int c, input int d);
        return {W'(a), W'(b), W'(c), W'(d)};
    endfunction

    function automatic void model_clear();
        m_cnt = 0;
        for (int i = 0; i < 4; i++) m_sum[i] = 0;
    endfunction

    function automatic void model_beat(input logic [1:0] p, input logic [15:0] d);
        int v;
        int lane[4];
        v = int'(d);
        if (m_cnt == 0) m_prec = (p == 2'b10) ? 2'b11 : p;
        case (m_prec)
            2'b00:   lane = '{v, 0, 0, 0};
            2'b01:   lane = '{v / 256, v % 256, 0, 0};
            default: lane = '{v / 4096, (v / 256) % 16, (v / 16) % 16, v % 16};
        endcase
        for (int i = 0; i < 4; i++) m_sum[i] += lane[i];
        m_cnt++;
        if (m_cnt == L) begin
            exp_q.push_back({m_prec, pk(m_sum[0], m_sum[1], m_sum[2], m_sum[3])});
            model_clear();
        end
    endfunction

    // One cycle, entered just after a falling edge with inputs already driven.
    task automatic step(output bit accepted);
        logic        exp_rdy;
        logic [81:0] e;
        #1;
        exp_rdy = !flush && !(m_cnt == L - 1 && exp_q.size() != 0 && !out_ready);
        check_eq("in_ready", 80'(in_ready), 80'(exp_rdy));
        check_eq("out_valid", 80'(out_valid), 80'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            check_eq("out_data", out_data, e[79:0]);
            check_eq("out_prec", 80'(out_prec), 80'(e[81:80]));
            if (out_ready) void'(exp_q.pop_front());
        end
        accepted = 1'b0;
        if (flush) begin
            model_clear();
        end else if (in_valid && exp_rdy) begin
            model_beat(prec, in_data);
            accepted = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic send_beat(input logic [1:0] p, input logic [15:0] d);
        bit got;
        got = 1'b0;
        prec = p;
        in_data = d;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) step(got);
        in_valid = 1'b0;
        check_eq("beat_accept", 80'(got), 80'(1));
    endtask

    task automatic expect_out(input string tag, input logic [79:0] d, input logic [1:0] p);
        #1;
        check_eq({tag, "_valid"}, 80'(out_valid), 80'(1));
        check_eq({tag, "_data"}, out_data, d);
        check_eq({tag, "_prec"}, 80'(out_prec), 80'(p));
    endtask

    initial begin
        bit got;
        int pick;
        model_clear();

        // Reset state
        #3;
        check_eq("rst_out_valid", 80'(out_valid), 80'(0));
        check_eq("rst_out_data", out_data, 80'(0));
        check_eq("rst_out_prec", 80'(out_prec), 80'(0));
        check_eq("rst_in_ready", 80'(in_ready), 80'(0));
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // 4x4: four beats of 0x00E1
        for (int i = 0; i < 4; i++) send_beat(2'b00, 16'h00E1);
        expect_out("s1", pk(900, 0, 0, 0), 2'b00);
        idle(2);

        // 2x2: four beats of 0x1234
        for (int i = 0; i < 4; i++) send_beat(2'b11, 16'h1234);
        expect_out("s2", pk(4, 8, 12, 16), 2'b11);
        idle(1);

        // 4x2: max-value words
        for (int i = 0; i < 4; i++) send_beat(2'b01, 16'hFFFF);
        expect_out("s3", pk(1020, 1020, 0, 0), 2'b01);
        idle(1);

        // Backpressure across two windows
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(2'b00, 16'h0010);
        for (int i = 0; i < 3; i++) send_beat(2'b00, 16'h0100);
        prec = 2'b00;
        in_data = 16'h0100;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(got);
            check_eq("held_off", 80'(got), 80'(0));
        end
        expect_out("s4a", pk(64, 0, 0, 0), 2'b00);
        out_ready = 1'b1;
        step(got);
        check_eq("refill", 80'(got), 80'(1));
        in_valid = 1'b0;
        out_ready = 1'b0;
        expect_out("s4b", pk(1024, 0, 0, 0), 2'b00);
        idle(2);
        out_ready = 1'b1;
        idle(2);

        // Precision change mid-window is ignored
        send_beat(2'b11, 16'h1111);
        for (int i = 0; i < 3; i++) send_beat(2'b00, 16'h1111);
        expect_out("s5", pk(4, 4, 4, 4), 2'b11);
        idle(1);

        // Flush mid-window, with a beat offered during the flush
        send_beat(2'b00, 16'hFFFF);
        send_beat(2'b00, 16'hFFFF);
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = 16'hFFFF;
        step(got);
        check_eq("flush_no_accept", 80'(got), 80'(0));
        flush = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(2'b00, 16'h0001);
        expect_out("s6", pk(4, 0, 0, 0), 2'b00);
        idle(1);

        // Reset mid-window with a result pending
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(2'b01, 16'h0102);
        send_beat(2'b00, 16'hFFFF);
        send_beat(2'b00, 16'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 80'(out_valid), 80'(0));
        check_eq("midrst_in_ready", 80'(in_ready), 80'(0));
        check_eq("midrst_out_data", out_data, 80'(0));
        exp_q.delete();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(2'b11, 16'h1234);
        expect_out("s7", pk(4, 8, 12, 16), 2'b11);
        idle(1);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            pick = $urandom_range(0, 2);
            prec = (pick == 0) ? 2'b00 : (pick == 1) ? 2'b01 : 2'b11;
            in_data = 16'($urandom);
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 99) < 3);
            step(got);
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        idle(3);
        check_eq("drained", 80'(exp_q.size()), 80'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
